// File: rtl/tx_d2c_point_test_if.sv
// tx_d2c_point_test_if: request, sideband and pattern-control signals of the D2C point test
interface tx_d2c_point_test_if;
  logic        i_en;
  logic        i_perlane;
  logic        i_mainband;
  logic [3:0]  i_RX_SbMessage;
  logic        i_msg_valid;
  logic [15:0] i_sb_data;
  logic        i_falling_edge_busy;
  logic [3:0]  o_TX_SbMessage;
  logic        o_ValidOutData;
  logic [2:0]  o_msg_info;
  logic        o_pattern_en;
  logic        o_done;
  logic [15:0] o_Result;
  logic        o_timeout;
  modport master (
    output i_en, i_perlane, i_mainband, i_RX_SbMessage, i_msg_valid, i_sb_data, i_falling_edge_busy,
    input  o_TX_SbMessage, o_ValidOutData, o_msg_info, o_pattern_en, o_done, o_Result, o_timeout
  );
  modport slave (
    input  i_en, i_perlane, i_mainband, i_RX_SbMessage, i_msg_valid, i_sb_data, i_falling_edge_busy,
    output o_TX_SbMessage, o_ValidOutData, o_msg_info, o_pattern_en, o_done, o_Result, o_timeout
  );
endinterface

// File: rtl/tx_d2c_point_test.sv
// tx_d2c_point_test: transmitter-initiated D2C point test sequencer; define D2C_TIMEOUT_EN for the handshake timeout
module tx_d2c_point_test #(
  parameter int PATTERN_CYCLES = 4096,
  parameter int CNT_W          = 13,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input logic                CLK,
  input logic                rst_n,
  tx_d2c_point_test_if.slave bus
);
  localparam logic [3:0] START_REQ     = 4'd1;
  localparam logic [3:0] START_RESP    = 4'd2;
  localparam logic [3:0] LFSR_CLR_REQ  = 4'd3;
  localparam logic [3:0] LFSR_CLR_RESP = 4'd4;
  localparam logic [3:0] RESULT_REQ    = 4'd5;
  localparam logic [3:0] RESULT_RESP   = 4'd6;
  localparam logic [3:0] END_REQ       = 4'd7;
  localparam logic [3:0] END_RESP      = 4'd8;

  if (TIMEOUT_CYCLES < 2 || (2 ** CNT_W) <= PATTERN_CYCLES) begin : g_bad_cfg
    $error("tx_d2c_point_test: CNT_W too small for PATTERN_CYCLES or TIMEOUT_CYCLES < 2");
  end

  typedef enum logic [3:0] {
    IDLE, SEND_START, WAIT_START, SEND_LFSR, WAIT_LFSR, PATTERN,
    SEND_RESULT, WAIT_RESULT, SEND_END, WAIT_END, DONE
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       rx_code;
  logic             tmo;
  logic [3:0]       tx_d;
  logic             pat_d, done_d, acc_res;
  logic [2:0]       info_d;
  logic [15:0]      res_d;

  // an unstrobed message reads as code 0, which no wait state accepts
  assign rx_code = bus.i_msg_valid ? bus.i_RX_SbMessage : 4'd0;

`ifdef D2C_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;
  logic          hs;
  assign hs  = state inside {SEND_START, WAIT_START, SEND_LFSR, WAIT_LFSR,
                             SEND_RESULT, WAIT_RESULT, SEND_END, WAIT_END};
  assign tmo = hs && tcnt == TW'(TIMEOUT_CYCLES - 1);
  // handshake watchdog, restarted on every state change
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) tcnt <= '0;
    else tcnt <= (hs && next_state == state) ? tcnt + 1'b1 : '0;
  // timeout flag lives exactly as long as the DONE it caused
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) bus.o_timeout <= 1'b0;
    else bus.o_timeout <= next_state == DONE && (tmo || bus.o_timeout);
`else
  assign tmo           = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  // state and pattern counter; the counter is zero outside PATTERN so every entry starts clean
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= (state == PATTERN && next_state == PATTERN) ? cnt + 1'b1 : '0;
    end

  // handshake sequencing; timeout overrides progress and an abort overrides everything
  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (bus.i_en) next_state = SEND_START;
      SEND_START:  if (bus.i_falling_edge_busy) next_state = WAIT_START;
      WAIT_START:  if (rx_code == START_RESP) next_state = SEND_LFSR;
      SEND_LFSR:   if (bus.i_falling_edge_busy) next_state = WAIT_LFSR;
      WAIT_LFSR:   if (rx_code == LFSR_CLR_RESP) next_state = PATTERN;
      PATTERN:     if (cnt == CNT_W'(PATTERN_CYCLES - 1)) next_state = SEND_RESULT;
      SEND_RESULT: if (bus.i_falling_edge_busy) next_state = WAIT_RESULT;
      WAIT_RESULT: if (rx_code == RESULT_RESP) next_state = SEND_END;
      SEND_END:    if (bus.i_falling_edge_busy) next_state = WAIT_END;
      WAIT_END:    if (rx_code == END_RESP) next_state = DONE;
      DONE:        if (!bus.i_en) next_state = IDLE;
      default:     next_state = IDLE;
    endcase
    if (tmo) next_state = DONE;
    if (!bus.i_en && state != IDLE && state != DONE) next_state = IDLE;
  end

  // next output values decoded from the upcoming state so outputs move with the state register
  always_comb begin
    tx_d    = next_state == SEND_START  ? START_REQ :
              next_state == SEND_LFSR   ? LFSR_CLR_REQ :
              next_state == SEND_RESULT ? RESULT_REQ :
              next_state == SEND_END    ? END_REQ : 4'd0;
    pat_d   = next_state == PATTERN;
    done_d  = next_state == DONE;
    info_d  = (state == IDLE && next_state == SEND_START) ?
              {bus.i_mainband, bus.i_perlane, 1'b0} : bus.o_msg_info;
    acc_res = state == WAIT_RESULT && next_state == SEND_END;
    res_d   = (tmo && next_state == DONE) ? 16'h0000 :
              !acc_res ? bus.o_Result :
              bus.o_msg_info[1] ? bus.i_sb_data : {16{bus.i_sb_data[0]}};
  end

  // registered outputs
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      bus.o_TX_SbMessage <= 4'd0;
      bus.o_ValidOutData <= 1'b0;
      bus.o_msg_info     <= 3'd0;
      bus.o_pattern_en   <= 1'b0;
      bus.o_done         <= 1'b0;
      bus.o_Result       <= 16'h0000;
    end else begin
      bus.o_TX_SbMessage <= tx_d;
      bus.o_ValidOutData <= tx_d != 4'd0;
      bus.o_msg_info     <= info_d;
      bus.o_pattern_en   <= pat_d;
      bus.o_done         <= done_d;
      bus.o_Result       <= res_d;
    end
endmodule

// File: doc/tx_d2c_point_test.md
Name: tx_d2c_point_test

Overview:
- Executes the Transmitter-initiated Data-to-Clock point test requested by the MBINIT REPAIRMB/REVERSALMB controllers, which raise an enable plus mode bits and wait for done and a 16-bit per-lane result.
- Sequences the sideband handshake with the partner: start, LFSR clear, pattern burst, result, end.
- Drives the local mainband pattern generator for a fixed cycle count.
- Returns the partner-reported lane results to the caller.

Parameters:
- PATTERN_CYCLES, 4096: cycles `o_pattern_en` is held high per test.
- CNT_W, 13: pattern counter width; must satisfy 2^CNT_W > PATTERN_CYCLES.
- TIMEOUT_CYCLES, 800000: handshake timeout. Used only with `D2C_TIMEOUT_EN`.

Ports:
- CLK  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_en  in  1  test request from the REPAIRMB controller; level, held until done is seen
- i_perlane  in  1  1 = per-lane compare, 0 = aggregate compare
- i_mainband  in  1  1 = mainband data lanes, 0 = valid/track lanes
- i_RX_SbMessage  in  4  decoded received sideband message
- i_msg_valid  in  1  `i_RX_SbMessage` valid strobe (1 cycle)
- i_sb_data  in  16  data field of the received sideband message
- i_falling_edge_busy  in  1  sideband transmitter finished the current message
- o_TX_SbMessage  out  4  message to send
- o_ValidOutData  out  1  send request; held until `i_falling_edge_busy`
- o_msg_info  out  3  {i_mainband, i_perlane, 1'b0} latched at start
- o_pattern_en  out  1  mainband pattern generator enable
- o_done  out  1  test complete
- o_Result  out  16  lane pass mask (1 = pass)
- o_timeout  out  1  test aborted by timeout (always 0 without the macro)

Behaviour:
- Message codes:
  - START_REQ=1, START_RESP=2
  - LFSR_CLR_REQ=3, LFSR_CLR_RESP=4
  - RESULT_REQ=5, RESULT_RESP=6
  - END_REQ=7, END_RESP=8
- Reset values: all outputs 0; state IDLE; counters 0.
- States and transitions:
  - IDLE: latch mode bits on `i_en` rising (`i_en` high and state IDLE) and go to SEND_START. Stay otherwise.
  - SEND_x (START, LFSR, RESULT, END): drive `o_TX_SbMessage`=x_REQ with `o_ValidOutData`=1. On `i_falling_edge_busy`, drop valid next cycle and go to WAIT_x.
  - WAIT_x: on `i_msg_valid` with message x_RESP, advance.
    - START → SEND_LFSR.
    - LFSR → PATTERN.
    - RESULT → capture `i_sb_data`, then SEND_END.
    - END → DONE.
    - Any other message, or a message without `i_msg_valid`, is ignored.
  - PATTERN: `o_pattern_en`=1 for exactly PATTERN_CYCLES cycles. Counter clears on entry and increments each cycle. At count = PATTERN_CYCLES-1, the next state is SEND_RESULT and `o_pattern_en` falls.
  - DONE: `o_done`=1 and `o_Result` stable while `i_en`=1. When `i_en`=0, return to IDLE next cycle; `o_done` clears and `o_Result` holds its value.
- Result rules:
  - Per-lane: `o_Result` = `i_sb_data`.
  - Aggregate: `o_Result` = {16{i_sb_data[0]}}.
  - `o_Result` updates only in the cycle the RESULT_RESP is accepted.
- Output registering: `o_TX_SbMessage` is 0 whenever `o_ValidOutData`=0. All outputs are registered, so each takes effect one cycle after its state entry.
- Abort: `i_en` deasserted in any state other than IDLE or DONE → next cycle IDLE.
  - Clears valid, `o_pattern_en`, counters, and `o_done`.
  - A sideband message already in flight is dropped; its busy edge is ignored in IDLE.
- Simultaneous events:
  - `i_falling_edge_busy` and `i_msg_valid` in the same cycle while in SEND: only the busy edge is processed and the message is lost. The partner responds only after the request completes, so this is legal.
  - `i_en` falling in the same cycle as a state advance: abort wins.
- Minimum test duration from `i_en` to `o_done` = PATTERN_CYCLES + 4 handshakes + 2 cycles.

Optional Feature:
- Macro `D2C_TIMEOUT_EN`.
- When defined:
  - A counter runs in every SEND/WAIT state and resets on each state change.
  - Reaching TIMEOUT_CYCLES-1 forces DONE with `o_timeout`=1 and `o_Result`=16'h0000.
  - `o_timeout` clears with `o_done`.
- When undefined: the counter logic is absent, `o_timeout` is tied to 0, and WAIT states can stall indefinitely.

Test Plan:
- Per-lane nominal: `i_perlane`=1, `i_mainband`=1, each response arrives 3 cycles after busy falls, RESULT_RESP data 16'hF0F3.
  - Message order 1,3,(pattern),5,7.
  - `o_pattern_en` high exactly 4096 cycles.
  - `o_done`=1 with `o_Result`=16'hF0F3; `o_msg_info`=3'b110.
- Aggregate mode: `i_perlane`=0, data 16'h0001 → `o_Result`=16'hFFFF. Repeat with data 16'hFFFE → `o_Result`=16'h0000.
- Spurious messages: in WAIT_START inject RESULT_RESP (6) and code 2 with `i_msg_valid`=0 → state unchanged. A valid START_RESP then advances to LFSR_CLR_REQ.
- Abort: drop `i_en` at pattern cycle 100 → next cycle `o_pattern_en`=0, state IDLE, `o_done`=0. Re-raising `i_en` restarts from START_REQ with the counter at 0.
- Reset mid-operation: assert `rst_n`=0 asynchronously during SEND_RESULT → all outputs 0 immediately without a clock edge.
- Timeout (`D2C_TIMEOUT_EN`, TIMEOUT_CYCLES=50): withhold END_RESP → `o_done`=1, `o_timeout`=1, `o_Result`=0 exactly 50 cycles after WAIT_END entry.
